ex_count_mon: RTL and testbench

//   Receive-side checker for the square wave from the example counter (e.g. ex_count_out looped back via pmod).

---
 rtl/ex_count_mon_if.sv | 35 +++
 rtl/ex_count_mon.sv | 177 +++++++++++++++++
 tb/tb_ex_count_mon.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_count_mon_if.sv
// Monitor status bundle: looped-back square wave and clear in, period/lock/error status out.
// EX_MON_MINMAX_EN adds min_period/max_period to the modports.
interface ex_count_mon_if #(
    parameter int CNT_W = 24
);
    logic             sig_in;
    logic             clr_err;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             ok;
    logic             err;
    logic             timeout;
    logic [CNT_W-1:0] min_period;
    logic [CNT_W-1:0] max_period;

`ifdef EX_MON_MINMAX_EN
    modport master (
        output sig_in, clr_err,
        input  period, period_vld, ok, err, timeout, min_period, max_period
    );
    modport slave (
        input  sig_in, clr_err,
        output period, period_vld, ok, err, timeout, min_period, max_period
    );
`else
    modport master (
        output sig_in, clr_err,
        input  period, period_vld, ok, err, timeout
    );
    modport slave (
        input  sig_in, clr_err,
        output period, period_vld, ok, err, timeout
    );
`endif
endinterface

// File: rtl/ex_count_mon.sv
// Period/lock checker for an asynchronous square wave, measured in safe_clk cycles.
// Define EX_MON_MINMAX_EN to also track min/max period since the last clr_err.
module ex_count_mon #(
    parameter int CNT_W      = 24,
    parameter int EXP_PERIOD = 1000000,
    parameter int TOL        = 16,
    parameter int LOCK_N     = 4,
    parameter int TIMEOUT    = 2000000
) (
    input logic            safe_clk,
    input logic            safe_reset_n,
    ex_count_mon_if.slave  mon
);
    localparam int GW = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]   EXP_X    = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]   TOL_X    = (CNT_W+1)'(TOL);
    localparam logic [GW-1:0]    LOCK_G   = GW'(LOCK_N);

    typedef enum logic [1:0] {IDLE, ARM, RUN, TMO} state_t;

    state_t           state, state_nxt;
    logic             sync_a, sync_b, hist;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] meas;
    logic [CNT_W:0]   meas_x;
    logic             in_rng;
    logic             publish, to_enter, err_set;
    logic [GW-1:0]    good_cnt, good_inc;

    logic [CNT_W-1:0] period_q;
    logic             vld_q, ok_q, err_q, to_q;

    // sync_a/sync_b resolve metastability; hist holds the previous settled level
    always_ff @(posedge safe_clk or negedge safe_reset_n) begin
        if (!safe_reset_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            hist   <= 1'b0;
        end else begin
            sync_a <= mon.sig_in;
            sync_b <= sync_a;
            hist   <= sync_b;
        end
    end

    assign rise = sync_b & ~hist;

    // Free-running distance counter, saturating so a dead input never aliases
    always_ff @(posedge safe_clk or negedge safe_reset_n) begin
        if (!safe_reset_n)
            cnt <= '0;
        else if (rise)
            cnt <= '0;
        else if (cnt != '1)
            cnt <= cnt + CNT_W'(1);
    end

    assign meas   = cnt + CNT_W'(1);
    assign meas_x = {1'b0, meas};
    // Lower bound written as meas+TOL >= EXP so a TOL larger than EXP cannot underflow
    assign in_rng = ((meas_x + TOL_X) >= EXP_X) && (meas_x <= (EXP_X + TOL_X));

    always_ff @(posedge safe_clk or negedge safe_reset_n) begin
        if (!safe_reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        publish   = 1'b0;
        to_enter  = 1'b0;
        case (state)
            IDLE: if (rise) state_nxt = ARM;
            ARM, RUN: begin
                if (rise) begin
                    state_nxt = RUN;
                    publish   = 1'b1;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = TMO;
                    to_enter  = 1'b1;
                end
            end
            TMO: if (rise) state_nxt = ARM;
            default: state_nxt = IDLE;
        endcase
    end

    assign good_inc = (good_cnt == LOCK_G) ? good_cnt : good_cnt + GW'(1);
    assign err_set  = to_enter | (publish & ~in_rng);

    always_ff @(posedge safe_clk or negedge safe_reset_n) begin
        if (!safe_reset_n) begin
            period_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            vld_q <= publish;
            if (publish)
                period_q <= meas;
        end
    end

    always_ff @(posedge safe_clk or negedge safe_reset_n) begin
        if (!safe_reset_n) begin
            good_cnt <= '0;
            ok_q     <= 1'b0;
        end else if (to_enter) begin
            good_cnt <= '0;
            ok_q     <= 1'b0;
        end else if (publish) begin
            if (in_rng) begin
                good_cnt <= good_inc;
                ok_q     <= (good_inc == LOCK_G);
            end else begin
                good_cnt <= '0;
                ok_q     <= 1'b0;
            end
        end
    end

    always_ff @(posedge safe_clk or negedge safe_reset_n) begin
        if (!safe_reset_n)
            to_q <= 1'b0;
        else if (to_enter)
            to_q <= 1'b1;
        else if (state == TMO && rise)
            to_q <= 1'b0;
    end

    // A new error in the same cycle as clr_err must not be lost
    always_ff @(posedge safe_clk or negedge safe_reset_n) begin
        if (!safe_reset_n)
            err_q <= 1'b0;
        else if (err_set)
            err_q <= 1'b1;
        else if (mon.clr_err)
            err_q <= 1'b0;
    end

    assign mon.period     = period_q;
    assign mon.period_vld = vld_q;
    assign mon.ok         = ok_q;
    assign mon.err        = err_q;
    assign mon.timeout    = to_q;

`ifdef EX_MON_MINMAX_EN
    logic [CNT_W-1:0] min_q, max_q;

    always_ff @(posedge safe_clk or negedge safe_reset_n) begin
        if (!safe_reset_n) begin
            min_q <= '1;
            max_q <= '0;
        end else if (mon.clr_err) begin
            min_q <= publish ? meas : '1;
            max_q <= publish ? meas : '0;
        end else if (publish) begin
            if (meas < min_q) min_q <= meas;
            if (meas > max_q) max_q <= meas;
        end
    end

    assign mon.min_period = min_q;
    assign mon.max_period = max_q;
`endif

    // Rising edges are at least two cycles apart, so strobes never abut
    a_vld_single: assert property (@(posedge safe_clk) disable iff (!safe_reset_n)
        mon.period_vld |=> !mon.period_vld);
    a_to_not_ok: assert property (@(posedge safe_clk) disable iff (!safe_reset_n)
        mon.timeout |-> !mon.ok);
    a_err_sticky: assert property (@(posedge safe_clk) disable iff (!safe_reset_n)
        $fell(mon.err) |-> $past(mon.clr_err));

endmodule

// File: tb/tb_ex_count_mon.sv
// Randomised bench for ex_count_mon, checked against an edge-timestamp reference model.
module tb_ex_count_mon;
    localparam int CNT_W = 16;
    localparam int EXP   = 100;
    localparam int TOL   = 2;
    localparam int LOCK  = 4;
    localparam int TMO   = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_count_mon_if #(.CNT_W(CNT_W)) mon();

    ex_count_mon #(
        .CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_N(LOCK), .TIMEOUT(TMO)
    ) dut (
        .safe_clk    (clk),
        .safe_reset_n(rst_n),
        .mon         (mon.slave)
    );

    int n_chk = 0;
    int n_fail = 0;

    // reference model: edges as timestamps, period = distance between edge cycles
    int          w, t_last, good;
    bit          have_ref;
    logic        s0, s1, e_prev;
    logic        m_vld, m_ok, m_err, m_to;
    logic [15:0] m_per, m_min, m_max;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        w = 0; t_last = 0; good = 0; have_ref = 0;
        s0 = 0; s1 = 0; e_prev = 0;
        m_vld = 0; m_ok = 0; m_err = 0; m_to = 0;
        m_per = '0; m_min = 16'hFFFF; m_max = '0;
    endtask

    task automatic model_step(input logic s, input logic c);
        logic e, set;
        int p;
        w++;
        e = e_prev; set = 0; m_vld = 0; p = 0;
        if (have_ref) begin
            if (e) begin
                p = (w - 1) - t_last;
                t_last = w - 1;
                m_vld = 1;
                m_per = p[15:0];
                if (p >= EXP - TOL && p <= EXP + TOL) begin
                    if (good < LOCK) good++;
                    m_ok = (good == LOCK);
                end else begin
                    good = 0; m_ok = 0; set = 1;
                end
            end else if ((w - 1) - t_last == TMO) begin
                have_ref = 0; m_to = 1; m_ok = 0; good = 0; set = 1;
            end
        end else if (e) begin
            have_ref = 1; t_last = w - 1; m_to = 0;
        end
        if (set) m_err = 1;
        else if (c) m_err = 0;
        if (c) begin
            m_min = m_vld ? p[15:0] : 16'hFFFF;
            m_max = m_vld ? p[15:0] : 16'h0000;
        end else if (m_vld) begin
            if (p[15:0] < m_min) m_min = p[15:0];
            if (p[15:0] > m_max) m_max = p[15:0];
        end
        e_prev = s0 & ~s1;
        s1 = s0;
        s0 = s;
    endtask

    task automatic chk_all();
        chk("period_vld", mon.period_vld, m_vld);
        chk("period", mon.period, m_per);
        chk("ok", mon.ok, m_ok);
        chk("err", mon.err, m_err);
        chk("timeout", mon.timeout, m_to);
`ifdef EX_MON_MINMAX_EN
        chk("min_period", mon.min_period, m_min);
        chk("max_period", mon.max_period, m_max);
`endif
    endtask

    // one cycle: check at negedge, drive, clock, advance model
    task automatic cyc(input logic s, input logic c);
        chk_all();
        mon.sig_in = s;
        mon.clr_err = c;
        @(posedge clk);
        model_step(s, c);
        @(negedge clk);
    endtask

    task automatic wave(input int per, input int hi, input int clr_at);
        for (int i = 0; i < per; i++)
            cyc(i < hi, i == clr_at);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vld"}, mon.period_vld, 0);
        chk({tag, "_period"}, mon.period, 0);
        chk({tag, "_ok"}, mon.ok, 0);
        chk({tag, "_err"}, mon.err, 0);
        chk({tag, "_timeout"}, mon.timeout, 0);
    endtask

    int per_tab [10] = '{98, 99, 100, 101, 102, 97, 103, 110, 100, 100};

    initial begin
        mon.sig_in = 1'b0;
        mon.clr_err = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // lock on a clean period-100 wave
        repeat (6) wave(EXP, 50, -1);
        chk("lock_ok", mon.ok, 1);
        chk("lock_err", mon.err, 0);
        chk("lock_timeout", mon.timeout, 0);

        // single 103 period breaks lock; four good periods restore it
        wave(103, 50, -1);
        repeat (4) wave(EXP, 50, -1);
        chk("relock_pending_ok", mon.ok, 0);
        chk("oor_err", mon.err, 1);
        wave(EXP, 50, -1);
        chk("relock_ok", mon.ok, 1);

        // clr_err alone, then inclusive bounds 98/102 keep lock
        wave(EXP, 50, 20);
        chk("clr_alone_err", mon.err, 0);
        wave(98, 40, -1);
        wave(102, 60, -1);
        wave(EXP, 50, -1);
        chk("bounds_ok", mon.ok, 1);
        chk("bounds_err", mon.err, 0);

        // clr_err coincident with a 110 period being published
        wave(110, 50, -1);
        wave(EXP, 50, 2);
        chk("clr_collide_err", mon.err, 1);

        // dead input -> timeout, then restart
        repeat (400) cyc(1'b0, 1'b0);
        chk("to_timeout", mon.timeout, 1);
        chk("to_err", mon.err, 1);
        chk("to_ok", mon.ok, 0);
        wave(EXP, 50, -1);
        wave(EXP, 50, -1);
        chk("restart_period", mon.period, EXP);
        chk("restart_timeout", mon.timeout, 0);

        // min/max over 99,101,100 after a clear
        wave(99, 50, 5);
        wave(101, 50, -1);
        wave(EXP, 50, -1);
        wave(EXP, 50, -1);
`ifdef EX_MON_MINMAX_EN
        chk("mm_min", mon.min_period, 99);
        chk("mm_max", mon.max_period, 101);
`endif
        cyc(1'b1, 1'b1);
`ifdef EX_MON_MINMAX_EN
        chk("mm_clr_min", mon.min_period, 16'hFFFF);
        chk("mm_clr_max", mon.max_period, 0);
`endif
        wave(EXP, 50, -1);

        // asynchronous reset while locked
        repeat (5) wave(EXP, 50, -1);
        chk("pre_rst_ok", mon.ok, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) wave(EXP, 50, -1);
        chk("post_rst_ok", mon.ok, 1);

        // randomised periods, clears and dead gaps
        for (int k = 0; k < 40; k++) begin
            int per, hi, ca;
            per = per_tab[$urandom_range(0, 9)];
            hi  = $urandom_range(1, per - 1);
            ca  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, per - 1) : -1;
            wave(per, hi, ca);
            if ($urandom_range(0, 9) == 0)
                repeat ($urandom_range(180, 240)) cyc(1'b0, 1'b0);
        end
        chk_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
